// File: rtl/iob_rom_sp_arb2.sv
// Purpose: two-requester round-robin arbiter with bounded burst hold in front of one single-port sync ROM.
// Latency: grant/ready combinational in the request cycle; response pulse exactly 1 cycle after grant.
// Backpressure: requests stall via ready; no response backpressure (requester must take data on rsp valid).
//
// Ports:
//   clk_i, arst_i                      clock, asynchronous active-high reset
//   req{0,1}_valid_i / _addr_i         read requests from the two masters
//   req{0,1}_ready_o                   request accepted this cycle (at most one high)
//   rsp{0,1}_valid_o                   one-cycle read-data-valid pulse to the granted master
//   rsp_data_o                         shared read data, straight from the ROM
//   rom_en_o, rom_addr_o, rom_r_data_i ROM side (1-cycle read latency)
module iob_rom_sp_arb2 #(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic              clk_i,
    input  logic              arst_i,
    input  logic              req0_valid_i,
    input  logic [ADDR_W-1:0] req0_addr_i,
    output logic              req0_ready_o,
    output logic              rsp0_valid_o,
    input  logic              req1_valid_i,
    input  logic [ADDR_W-1:0] req1_addr_i,
    output logic              req1_ready_o,
    output logic              rsp1_valid_o,
    output logic [DATA_W-1:0] rsp_data_o,
    output logic              rom_en_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [DATA_W-1:0] rom_r_data_i
);

    localparam int                CNT_W   = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_0    = 2'd1,
        OWN_1    = 2'd2
    } owner_e;

    owner_e           owner_q, owner_d;
    logic             last_q, last_d;    // 1 = requester 1 was granted last
    logic [CNT_W-1:0] cnt_q, cnt_d;      // consecutive grants to the current owner, saturating
    logic             rsp0_q, rsp1_q;

    logic   any_vld;
    logic   gnt1;                        // meaningful only when any_vld
    owner_e gnt_own;

    // Arbitration and next-state.
    always_comb begin
        any_vld = req0_valid_i | req1_valid_i;
        gnt1    = 1'b0;
        if (req0_valid_i && req1_valid_i) begin
            // Under contention the owner keeps the port until its burst is used up,
            // then the requester that was not granted last wins.
            if (owner_q != OWN_NONE && cnt_q < MAX_CNT) begin
                gnt1 = (owner_q == OWN_1);
            end else begin
                gnt1 = ~last_q;
            end
        end else begin
            gnt1 = req1_valid_i;
        end
        gnt_own = gnt1 ? OWN_1 : OWN_0;

        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        if (any_vld) begin
            last_d  = gnt1;
            owner_d = gnt_own;
            if (owner_q == gnt_own) begin
                cnt_d = (cnt_q == MAX_CNT) ? MAX_CNT : cnt_q + 1'b1;
            end else begin
                cnt_d = CNT_W'(1);
            end
        end else begin
            // An idle cycle ends any burst; the round-robin pointer is kept.
            owner_d = OWN_NONE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            owner_q <= OWN_NONE;
            last_q  <= 1'b1;             // requester 0 wins the first tie
            cnt_q   <= '0;
            rsp0_q  <= 1'b0;
            rsp1_q  <= 1'b0;
        end else begin
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            rsp0_q  <= any_vld & ~gnt1;
            rsp1_q  <= any_vld & gnt1;
        end
    end

    // Grant outputs are forced low while reset is held so no ROM read or
    // handshake is reported during reset.
    always_comb begin
        rom_en_o     = any_vld & ~arst_i;
        req0_ready_o = rom_en_o & ~gnt1;
        req1_ready_o = rom_en_o & gnt1;
        rom_addr_o   = '0;
        if (any_vld) begin
            rom_addr_o = gnt1 ? req1_addr_i : req0_addr_i;
        end
    end

    assign rsp0_valid_o = rsp0_q;
    assign rsp1_valid_o = rsp1_q;
    assign rsp_data_o   = rom_r_data_i;

endmodule

// File: tb/tb_iob_rom_sp_arb2.sv
// Purpose: self-checking bench for iob_rom_sp_arb2 with a behavioural arbiter model and ROM model.
// Latency: expects grant in the request cycle and the response one cycle later.
// Backpressure: responses are always consumed; requests are randomly withdrawn.
module tb_iob_rom_sp_arb2;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int MB = 4;

    logic          clk = 1'b0;
    logic          arst = 1'b1;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic [AW-1:0] req0_addr = '0, req1_addr = '0;
    logic          req0_ready, req1_ready, rsp0_valid, rsp1_valid;
    logic [DW-1:0] rsp_data;
    logic          rom_en;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_r_data = '0;

    iob_rom_sp_arb2 #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
        .clk_i        (clk),
        .arst_i       (arst),
        .req0_valid_i (req0_valid),
        .req0_addr_i  (req0_addr),
        .req0_ready_o (req0_ready),
        .rsp0_valid_o (rsp0_valid),
        .req1_valid_i (req1_valid),
        .req1_addr_i  (req1_addr),
        .req1_ready_o (req1_ready),
        .rsp1_valid_o (rsp1_valid),
        .rsp_data_o   (rsp_data),
        .rom_en_o     (rom_en),
        .rom_addr_o   (rom_addr),
        .rom_r_data_i (rom_r_data)
    );

    always #5 clk = ~clk;

    // ROM contents: word n holds 0xA5A5_0000 | n.
    function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
        return 32'hA5A5_0000 | {22'd0, a};
    endfunction

    always @(posedge clk) if (rom_en) rom_r_data <= rom_word(rom_addr);

    typedef struct { int g; logic [AW-1:0] addr; } gexp_t;
    typedef struct { int g; logic [DW-1:0] data; } rexp_t;

    gexp_t gq[$];
    rexp_t rq[$];
    int    glog[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    bit    chk_on = 1'b0;
    int    wait0 = 0, wait1 = 0;

    // Reference model: last grant, current owner and length of its current run.
    int m_last, m_owner, m_run;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_last = 1; m_owner = -1; m_run = 0;
    endtask

    // Drive one cycle of requests (caller is just after a rising edge) and
    // record what the arbiter must do with them.
    task automatic issue(input bit v0, input logic [AW-1:0] a0, input bit v1, input logic [AW-1:0] a1);
        int g;
        gexp_t ge;
        rexp_t re;
        req0_valid = v0; req0_addr = a0;
        req1_valid = v1; req1_addr = a1;
        if (v0 && v1) g = (m_owner >= 0 && m_run < MB) ? m_owner : 1 - m_last;
        else if (v0)  g = 0;
        else if (v1)  g = 1;
        else          g = -1;
        if (g >= 0) begin
            m_run   = (g == m_owner) ? m_run + 1 : 1;
            m_owner = g;
            m_last  = g;
        end else begin
            m_owner = -1;
            m_run   = 0;
        end
        ge.g = g; ge.addr = (g == 1) ? a1 : (g == 0) ? a0 : '0;
        re.g = g; re.data = rom_word(ge.addr);
        gq.push_back(ge);
        rq.push_back(re);
    endtask

    task automatic step(input bit v0, input logic [AW-1:0] a0, input bit v1, input logic [AW-1:0] a1);
        @(posedge clk); #1;
        issue(v0, a0, v1, a1);
    endtask

    task automatic release_reset();
        rexp_t none;
        @(posedge clk); #1;
        arst = 1'b0;
        model_reset();
        gq.delete(); rq.delete();
        none.g = -1; none.data = '0;
        rq.push_back(none);
        wait0 = 0; wait1 = 0;
        chk_on = 1'b1;
        issue(0, '0, 0, '0);
    endtask

    task automatic do_reset();
        chk_on = 1'b0;
        arst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (2) @(posedge clk);
        release_reset();
        @(negedge clk); #1;
        glog.delete();
    endtask

    // Monitor: checks grant outputs and responses once per cycle on the falling edge.
    always @(negedge clk) begin
        gexp_t e;
        rexp_t r;
        if (chk_on && !arst) begin
            if (gq.size() == 0) begin
                chk("grant_queue_empty", 1, 0);
            end else begin
                e = gq.pop_front();
                chk("ready0", req0_ready, e.g == 0);
                chk("ready1", req1_ready, e.g == 1);
                chk("rom_en", rom_en, e.g >= 0);
                chk("rom_addr", rom_addr, e.addr);
                glog.push_back(req0_ready ? 0 : req1_ready ? 1 : -1);
            end
            if (rq.size() == 0) begin
                chk("rsp_queue_empty", 1, 0);
            end else begin
                r = rq.pop_front();
                chk("rsp0_valid", rsp0_valid, r.g == 0);
                chk("rsp1_valid", rsp1_valid, r.g == 1);
                if (r.g >= 0) chk("rsp_data", rsp_data, r.data);
            end
            wait0 = (req0_valid && !req0_ready) ? wait0 + 1 : 0;
            wait1 = (req1_valid && !req1_ready) ? wait1 + 1 : 0;
            if (req0_valid) chk("starve0", wait0 > MB, 0);
            if (req1_valid) chk("starve1", wait1 > MB, 0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int p0, p1;
        model_reset();
        // Reset state with both requests asserted: nothing may be granted.
        req0_valid = 1'b1; req1_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rsp0", rsp0_valid, 0);
        chk("rst_rsp1", rsp1_valid, 0);
        chk("rst_en", rom_en, 0);
        chk("rst_ready0", req0_ready, 0);
        chk("rst_ready1", req1_ready, 0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        release_reset();

        // Single request from requester 0, address 5.
        step(1, 10'd5, 0, '0);
        step(0, '0, 0, '0);

        // First contended cycle after reset goes to requester 0.
        do_reset();
        step(1, 10'd1, 1, 10'd2);
        step(0, '0, 1, 10'd2);
        step(0, '0, 0, '0);
        @(negedge clk); #1;
        chk("t2_first", glog[0], 0);
        chk("t2_second", glog[1], 1);

        // Continuous contention: bursts of MB grants, alternating owners.
        do_reset();
        for (int i = 0; i < 12; i++) step(1, AW'($urandom), 1, AW'($urandom));
        step(0, '0, 0, '0);
        @(negedge clk); #1;
        for (int i = 0; i < 12; i++) chk($sformatf("t3_seq%0d", i), glog[i], (i / MB) % 2);

        // Requester 1 alone long enough to saturate, then requester 0 joins.
        do_reset();
        for (int i = 0; i < 10; i++) step(0, '0, 1, AW'(i));
        @(negedge clk); #1;
        glog.delete();
        for (int i = 0; i < 5; i++) step(1, AW'(100 + i), 1, AW'(200 + i));
        step(0, '0, 0, '0);
        @(negedge clk); #1;
        for (int i = 0; i < 5; i++) chk($sformatf("t4_seq%0d", i), glog[i], (i < MB) ? 0 : 1);

        // Reset while a response is pending.
        do_reset();
        step(1, 10'd7, 0, '0);
        @(posedge clk); #1;
        chk_on = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        arst = 1'b1;
        #1;
        chk("mid_rst_rsp0", rsp0_valid, 0);
        chk("mid_rst_rsp1", rsp1_valid, 0);
        chk("mid_rst_en", rom_en, 0);
        chk("mid_rst_ready0", req0_ready, 0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge clk);
        release_reset();
        @(negedge clk); #1;
        glog.delete();
        step(1, 10'd3, 1, 10'd4);
        step(0, '0, 0, '0);
        @(negedge clk); #1;
        chk("t5_restart", glog[0], 0);

        // Randomised traffic with varying request densities.
        for (int i = 0; i < 4000; i++) begin
            if (i % 500 == 0) begin
                p0 = int'($urandom_range(20, 100));
                p1 = int'($urandom_range(20, 100));
            end
            step($urandom_range(0, 99) < p0, AW'($urandom), $urandom_range(0, 99) < p1, AW'($urandom));
        end
        step(0, '0, 0, '0);
        @(negedge clk); #1;
        chk("drain_gq", gq.size(), 0);
        chk("drain_rq", rq.size(), 1);
        chk_on = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
